aux_uart_bridge: RTL and testbench

Memory-mapped peripheral on the PIC aux bus. It connects the core's aux address/data/strobe interface to the AXI-stream byte ports of the uart block.
- Transmit path: FIFO from aux writes to the uart input stream.
- Receive path: FIFO from the uart output stream to aux reads.
- Also provides status/control registers, a programmable prescale, and a level interrupt for the core's int0.

---
 rtl/aux_uart_bridge.sv | 130 +++++++++++++
 tb/tb_aux_uart_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aux_uart_bridge.sv
// Aux-bus peripheral bridging core register accesses to the uart byte streams.
// Holds TX/RX FIFOs, status/ctrl/prescale registers and a level interrupt.
module aux_uart_bridge #(
  parameter logic [15:0] BASE_ADDR      = 16'hFF00,
  parameter int          FIFO_AW        = 4,
  parameter logic [15:0] PRESCALE_RESET = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aux_adr_i,
  input  logic [7:0]  aux_dat_i,
  output logic [7:0]  aux_dat_o,
  output logic        aux_dat_oe,
  input  logic        aux_we_i,
  input  logic        aux_re_i,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic [15:0] prescale,
  output logic        irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       r_tx_mem [DEPTH];
  logic [7:0]       r_rx_mem [DEPTH];
  logic [FIFO_AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic             r_we_q, r_re_q;
  logic             r_rx_ovf, r_tx_ovf, r_rx_ie, r_tx_ie, r_irq;
  logic [15:0]      r_prescale;

  logic [15:0] w_off;
  logic        w_hit, w_we_fire, w_re_fire;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_tx_pop, w_tx_push_req, w_tx_push;
  logic        w_rx_pop, w_rx_push;
  logic        w_wr_ctrl;
  logic [7:0]  w_status, w_rd_dat, w_rx_head;

  // Offset via modular subtraction so the window never relies on BASE_ADDR+4 fitting.
  assign w_off     = aux_adr_i - BASE_ADDR;
  assign w_hit     = (w_off < 16'd5);
  assign w_we_fire = aux_we_i & ~r_we_q & w_hit;
  assign w_re_fire = aux_re_i & ~r_re_q & w_hit;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[FIFO_AW] != r_tx_rp[FIFO_AW]) &&
                      (r_tx_wp[FIFO_AW-1:0] == r_tx_rp[FIFO_AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[FIFO_AW] != r_rx_rp[FIFO_AW]) &&
                      (r_rx_wp[FIFO_AW-1:0] == r_rx_rp[FIFO_AW-1:0]);

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign w_tx_pop      = ~w_tx_empty & tx_tready;
  assign w_tx_push_req = w_we_fire & (w_off[2:0] == 3'd0);
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_rx_pop      = w_re_fire & (w_off[2:0] == 3'd0) & ~w_rx_empty;
  assign w_rx_push     = rx_tvalid & (~w_rx_full | w_rx_pop);
  assign w_wr_ctrl     = w_we_fire & (w_off[2:0] == 3'd2);

  assign w_rx_head = r_rx_mem[r_rx_rp[FIFO_AW-1:0]];
  assign w_status  = {2'b00, r_tx_ovf, r_irq, w_tx_empty, r_rx_ovf, ~w_tx_full, ~w_rx_empty};

  always_comb begin
    w_rd_dat = 8'h00;
    if (w_hit) begin
      case (w_off[2:0])
        3'd0:    w_rd_dat = w_rx_empty ? 8'h00 : w_rx_head;
        3'd1:    w_rd_dat = w_status;
        3'd2:    w_rd_dat = {6'b0, r_tx_ie, r_rx_ie};
        3'd3:    w_rd_dat = r_prescale[7:0];
        3'd4:    w_rd_dat = r_prescale[15:8];
        default: w_rd_dat = 8'h00;
      endcase
    end
  end

  assign aux_dat_oe = aux_re_i & w_hit & ~rst;
  assign aux_dat_o  = aux_dat_oe ? w_rd_dat : 8'h00;
  assign tx_tvalid  = ~w_tx_empty;
  assign tx_tdata   = r_tx_mem[r_tx_rp[FIFO_AW-1:0]];
  assign rx_tready  = 1'b1;
  assign prescale   = r_prescale;
  assign irq_o      = r_irq;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_AW-1:0]] <= aux_dat_i;
    if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_AW-1:0]] <= rx_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_we_q     <= 1'b0;
      r_re_q     <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_rx_ie    <= 1'b0;
      r_tx_ie    <= 1'b0;
      r_irq      <= 1'b0;
      r_prescale <= PRESCALE_RESET;
    end else begin
      r_we_q <= aux_we_i;
      r_re_q <= aux_re_i;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      // Sticky set beats a write-1 clear landing in the same cycle.
      r_tx_ovf <= (w_tx_push_req & ~w_tx_push) |
                  (r_tx_ovf & ~(w_wr_ctrl & aux_dat_i[3]));
      r_rx_ovf <= (rx_tvalid & ~w_rx_push) |
                  (r_rx_ovf & ~(w_wr_ctrl & aux_dat_i[2]));
      if (w_wr_ctrl) begin
        r_rx_ie <= aux_dat_i[0];
        r_tx_ie <= aux_dat_i[1];
      end
      if (w_we_fire && w_off[2:0] == 3'd3) r_prescale[7:0]  <= aux_dat_i;
      if (w_we_fire && w_off[2:0] == 3'd4) r_prescale[15:8] <= aux_dat_i;
      r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty);
    end
  end

endmodule

// File: tb/tb_aux_uart_bridge.sv
// Directed bench for aux_uart_bridge; aux reads and TX stream beats are checked from scoreboard queues.
module tb_aux_uart_bridge;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_DATA = BASE, A_STAT = BASE + 16'd1, A_CTRL = BASE + 16'd2;
  localparam logic [15:0] A_PLO = BASE + 16'd3, A_PHI = BASE + 16'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] aux_adr_i = 16'h0000;
  logic [7:0]  aux_dat_i = 8'h00;
  logic [7:0]  aux_dat_o;
  logic        aux_dat_oe;
  logic        aux_we_i = 1'b0;
  logic        aux_re_i = 1'b0;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready = 1'b0;
  logic [7:0]  rx_tdata = 8'h00;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [15:0] prescale;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic       re_prev = 1'b0;

  aux_uart_bridge #(.BASE_ADDR(BASE), .FIFO_AW(4), .PRESCALE_RESET(16'd1)) dut (
    .clk(clk), .rst(rst), .aux_adr_i(aux_adr_i), .aux_dat_i(aux_dat_i),
    .aux_dat_o(aux_dat_o), .aux_dat_oe(aux_dat_oe), .aux_we_i(aux_we_i),
    .aux_re_i(aux_re_i), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready), .prescale(prescale), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: first cycle of an aux read, and every accepted TX beat.
  always @(negedge clk) begin
    if (aux_re_i && !re_prev && aux_dat_oe) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL aux_read: unexpected read data %h", aux_dat_o);
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        if (aux_dat_o !== e) begin
          errors++;
          $display("FAIL aux_read @%h: got %h expected %h", aux_adr_i, aux_dat_o, e);
        end
      end
    end
    re_prev = aux_re_i;
    if (tx_tvalid && tx_tready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_beat: unexpected byte %h", tx_tdata);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (tx_tdata !== e) begin
          errors++;
          $display("FAIL tx_beat: got %h expected %h", tx_tdata, e);
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    aux_adr_i = a; aux_dat_i = d; aux_we_i = 1'b1;
    repeat (hold) @(posedge clk);
    #1 aux_we_i = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input int hold);
    @(posedge clk); #1;
    aux_adr_i = a; aux_re_i = 1'b1;
    rd_q.push_back(exp);
    repeat (hold) @(posedge clk);
    #1 aux_re_i = 1'b0;
  endtask

  task automatic rx_inj(input logic [7:0] b);
    @(posedge clk); #1;
    rx_tdata = b; rx_tvalid = 1'b1;
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_prescale", prescale, 16'd1);
    check("reset_tvalid", {15'b0, tx_tvalid}, 16'd0);
    check("reset_irq", {15'b0, irq_o}, 16'd0);
    check("reset_rx_tready", {15'b0, rx_tready}, 16'd1);
    rd(A_STAT, 8'h0A, 1);

    // Held write strobe yields a single TX entry.
    wr(A_DATA, 8'h55, 3);
    @(negedge clk);
    check("tx_tvalid_one", {15'b0, tx_tvalid}, 16'd1);
    check("tx_tdata_55", {8'b0, tx_tdata}, 16'h0055);
    tx_q.push_back(8'h55);
    @(posedge clk); #1 tx_tready = 1'b1;
    @(posedge clk); #1 tx_tready = 1'b0;
    @(negedge clk);
    check("tx_drained", {15'b0, tx_tvalid}, 16'd0);
    rd(A_STAT, 8'h0A, 1);

    // RX path with held read strobes.
    rx_inj(8'hA1); rx_inj(8'hA2); rx_inj(8'hA3);
    rd(A_DATA, 8'hA1, 2);
    rd(A_DATA, 8'hA2, 2);
    rd(A_DATA, 8'hA3, 2);
    rd(A_DATA, 8'h00, 2);
    rd(A_STAT, 8'h0A, 1);

    // TX overflow: 16 accepted, 17th dropped.
    for (int i = 0; i < 17; i++) wr(A_DATA, 8'h10 + 8'(i), 1);
    rd(A_STAT, 8'h20, 1);
    wr(A_CTRL, 8'h08, 1);
    rd(A_STAT, 8'h00, 1);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'h10 + 8'(i));
    @(posedge clk); #1 tx_tready = 1'b1;
    repeat (20) @(posedge clk);
    #1 tx_tready = 1'b0;
    rd(A_STAT, 8'h0A, 1);

    // RX interrupt timing.
    wr(A_CTRL, 8'h01, 1);
    rd(A_CTRL, 8'h01, 1);
    @(posedge clk); #1 rx_tdata = 8'h3C; rx_tvalid = 1'b1;
    @(posedge clk); #1 rx_tvalid = 1'b0;
    @(negedge clk);
    check("irq_not_yet", {15'b0, irq_o}, 16'd0);
    @(negedge clk);
    check("irq_rise", {15'b0, irq_o}, 16'd1);
    rd(A_STAT, 8'h1B, 1);
    rd(A_DATA, 8'h3C, 1);
    @(negedge clk);
    check("irq_hold", {15'b0, irq_o}, 16'd1);
    @(negedge clk);
    check("irq_fall", {15'b0, irq_o}, 16'd0);
    wr(A_CTRL, 8'h00, 1);

    // RX overflow and its write-1 clear.
    @(posedge clk); #1 rx_tdata = 8'h77; rx_tvalid = 1'b1;
    repeat (17) @(posedge clk);
    #1 rx_tvalid = 1'b0;
    rd(A_STAT, 8'h0F, 1);
    wr(A_CTRL, 8'h04, 1);
    rd(A_STAT, 8'h0B, 1);

    // Unmapped offset does not drive the bus.
    @(posedge clk); #1 aux_adr_i = BASE + 16'd5; aux_re_i = 1'b1;
    @(negedge clk);
    check("nohit_oe", {15'b0, aux_dat_oe}, 16'd0);
    check("nohit_dat", {8'b0, aux_dat_o}, 16'd0);
    @(posedge clk); #1 aux_re_i = 1'b0;

    // Prescale, then reset mid-transfer.
    wr(A_PLO, 8'h34, 1);
    wr(A_PHI, 8'h12, 1);
    @(negedge clk);
    check("prescale_1234", prescale, 16'h1234);
    rd(A_PLO, 8'h34, 1);
    rd(A_PHI, 8'h12, 1);
    for (int i = 0; i < 5; i++) wr(A_DATA, 8'hC0 + 8'(i), 1);
    @(negedge clk);
    check("tx_queued", {15'b0, tx_tvalid}, 16'd1);
    @(posedge clk); #1 rst = 1'b1; rx_tvalid = 1'b1; rx_tdata = 8'hEE;
    @(posedge clk); #1 rst = 1'b0; rx_tvalid = 1'b0;
    @(negedge clk);
    check("rst_tvalid", {15'b0, tx_tvalid}, 16'd0);
    check("rst_prescale", prescale, 16'd1);
    check("rst_irq", {15'b0, irq_o}, 16'd0);
    rd(A_STAT, 8'h0A, 1);

    repeat (2) @(negedge clk);
    check("rd_q_empty", 16'(rd_q.size()), 16'd0);
    check("tx_q_empty", 16'(tx_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
